// File: rtl/cmp_operand_loader.sv
// Serial-to-parallel loader for the equality comparator: shifts in operand E then F
// from a 1-bit stream and presents the pair under a valid/ready handshake.
module cmp_operand_loader #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             op_ready,
    output logic [WIDTH-1:0] e_out,
    output logic [WIDTH-1:0] f_out,
    output logic             op_valid,
    output logic             busy,
    output logic             frame_err,
    output logic [1:0]       dbg_state
);
    // Handshake: the pair on e_out/f_out is transferred on a rising edge where
    // op_valid and op_ready are both high; op_valid never drops without that transfer
    // (other than reset), and e_out/f_out stay stable while op_valid is high.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_E  = 2'd1,
        LOAD_F  = 2'd2,
        PRESENT = 2'd3
    } state_t;

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] e_sr;
    logic [WIDTH-1:0] f_sr;
    logic             in_load;
    logic             abort;
    logic             take_bit;
    logic             last_bit;
    logic             handshake;
    logic             clear_frame;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sr, input logic b);
        if (MSB_FIRST) return {sr[WIDTH-2:0], b};
        else           return {b, sr[WIDTH-1:1]};
    endfunction

    assign in_load   = (state == LOAD_E) || (state == LOAD_F);
    assign abort     = in_load && start;
    // A restarting start cycle never samples sin.
    assign take_bit  = in_load && !start && sin_valid;
    assign last_bit  = take_bit && (cnt == CW'(WIDTH - 1));
    assign handshake = (state == PRESENT) && op_ready;
    assign clear_frame = ((state == IDLE) && start) || abort || (handshake && start);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = LOAD_E;
            LOAD_E:  if (abort) state_nx = LOAD_E;
                     else if (last_bit) state_nx = LOAD_F;
            LOAD_F:  if (abort) state_nx = LOAD_E;
                     else if (last_bit) state_nx = PRESENT;
            PRESENT: if (handshake) state_nx = start ? LOAD_E : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        op_valid  = (state == PRESENT);
        busy      = in_load;
        dbg_state = state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            e_sr      <= '0;
            f_sr      <= '0;
            e_out     <= '0;
            f_out     <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= abort;
            if (clear_frame) begin
                cnt  <= '0;
                e_sr <= '0;
                f_sr <= '0;
            end else if (take_bit) begin
                cnt <= last_bit ? '0 : cnt + 1'b1;
                if (state == LOAD_E) e_sr <= shift_in(e_sr, sin);
                else                 f_sr <= shift_in(f_sr, sin);
                // Outputs are published only as the final F bit lands.
                if ((state == LOAD_F) && last_bit) begin
                    e_out <= e_sr;
                    f_out <= shift_in(f_sr, sin);
                end
            end
        end
    end

endmodule

// File: tb/tb_cmp_operand_loader.sv
// Directed bench for cmp_operand_loader: an MSB-first and an LSB-first instance share
// the same stimulus; expected values are hand-computed per step.
module tb_cmp_operand_loader;
    localparam logic [1:0] S_IDLE = 2'd0, S_LOAD_E = 2'd1, S_LOAD_F = 2'd2, S_PRESENT = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       sin = 1'b0;
    logic       sin_valid = 1'b0;
    logic       op_ready = 1'b0;
    logic [7:0] e_out, f_out, e_lsb, f_lsb;
    logic       op_valid, busy, frame_err, op_valid_lsb, busy_lsb, frame_err_lsb;
    logic [1:0] dbg_state, dbg_state_lsb;

    int errors = 0;
    int checks = 0;
    int cycle = 0;
    int t0;

    // clock / reset
    always #5 clk = ~clk;

    cmp_operand_loader #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .start(start), .sin(sin), .sin_valid(sin_valid),
        .op_ready(op_ready), .e_out(e_out), .f_out(f_out), .op_valid(op_valid),
        .busy(busy), .frame_err(frame_err), .dbg_state(dbg_state)
    );

    cmp_operand_loader #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .start(start), .sin(sin), .sin_valid(sin_valid),
        .op_ready(op_ready), .e_out(e_lsb), .f_out(f_lsb), .op_valid(op_valid_lsb),
        .busy(busy_lsb), .frame_err(frame_err_lsb), .dbg_state(dbg_state_lsb)
    );

    // driver tasks: inputs change 1 time unit after the edge, outputs read there too
    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends stream bits first..last of the 16-bit frame {E,F}; gap inserts an idle cycle before each bit.
    task automatic send_bits(input logic [7:0] e, input logic [7:0] f, input bit gap,
                             input bit lsb, input int first, input int last);
        logic [7:0] w;
        int j;
        for (int i = first; i <= last; i++) begin
            w = (i < 8) ? e : f;
            j = i % 8;
            if (gap) begin
                sin_valid = 1'b0;
                sin = 1'b1;
                tick();
            end
            sin_valid = 1'b1;
            sin = lsb ? w[j] : w[7-j];
            tick();
        end
        sin_valid = 1'b0;
        sin = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        // 1: reset
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_e", e_out, 8'h00);
        chk("rst_f", f_out, 8'h00);
        chk("rst_valid", op_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", frame_err, 1'b0);
        chk("rst_state", dbg_state, S_IDLE);
        rst_n = 1'b1;
        tick();

        // 2: contiguous A5/A5, consumer always ready
        op_ready = 1'b1;
        t0 = cycle;
        pulse_start();
        chk("t2_busy", busy, 1'b1);
        chk("t2_state_e", dbg_state, S_LOAD_E);
        send_bits(8'hA5, 8'hA5, 1'b0, 1'b0, 0, 7);
        chk("t2_state_f", dbg_state, S_LOAD_F);
        send_bits(8'hA5, 8'hA5, 1'b0, 1'b0, 8, 14);
        chk("t2_valid_early", op_valid, 1'b0);
        send_bits(8'hA5, 8'hA5, 1'b0, 1'b0, 15, 15);
        // start edge is cycle 0, bits on edges 1..16
        chk("t2_latency", cycle - t0, 17);
        chk("t2_valid", op_valid, 1'b1);
        chk("t2_busy_off", busy, 1'b0);
        chk("t2_e", e_out, 8'hA5);
        chk("t2_f", f_out, 8'hA5);
        chk("t2_eq", (e_out == f_out), 1'b1);
        tick();
        chk("t2_valid_drop", op_valid, 1'b0);
        chk("t2_idle", dbg_state, S_IDLE);

        // 3: 3C/3D with sin_valid low every other cycle, consumer stalled
        op_ready = 1'b0;
        t0 = cycle;
        pulse_start();
        send_bits(8'h3C, 8'h3D, 1'b1, 1'b0, 0, 14);
        chk("t3_valid_early", op_valid, 1'b0);
        chk("t3_e_old", e_out, 8'hA5);
        send_bits(8'h3C, 8'h3D, 1'b1, 1'b0, 15, 15);
        chk("t3_latency", cycle - t0, 33);
        chk("t3_valid", op_valid, 1'b1);
        chk("t3_e", e_out, 8'h3C);
        chk("t3_f", f_out, 8'h3D);
        chk("t3_eq", (e_out == f_out), 1'b0);

        // 4: hold in PRESENT for 5 cycles, start pulsed without handshake
        for (int k = 0; k < 5; k++) begin
            start = (k == 2);
            tick();
            chk("t4_valid_hold", op_valid, 1'b1);
            chk("t4_e_hold", e_out, 8'h3C);
            chk("t4_f_hold", f_out, 8'h3D);
            chk("t4_no_err", frame_err, 1'b0);
        end
        start = 1'b0;
        op_ready = 1'b1;
        tick();
        chk("t4_valid_drop", op_valid, 1'b0);
        chk("t4_idle", dbg_state, S_IDLE);
        op_ready = 1'b0;

        // 5: abort after 11 valid bits, then FF/00
        pulse_start();
        send_bits(8'h12, 8'h34, 1'b0, 1'b0, 0, 10);
        chk("t5_state_f", dbg_state, S_LOAD_F);
        start = 1'b1;
        sin_valid = 1'b1;
        sin = 1'b1;
        tick();
        start = 1'b0;
        sin_valid = 1'b0;
        chk("t5_err", frame_err, 1'b1);
        chk("t5_busy", busy, 1'b1);
        chk("t5_restart", dbg_state, S_LOAD_E);
        chk("t5_e_kept", e_out, 8'h3C);
        tick();
        chk("t5_err_pulse", frame_err, 1'b0);
        chk("t5_busy2", busy, 1'b1);
        send_bits(8'hFF, 8'h00, 1'b0, 1'b0, 0, 14);
        chk("t5_valid_early", op_valid, 1'b0);
        chk("t5_e_old", e_out, 8'h3C);
        send_bits(8'hFF, 8'h00, 1'b0, 1'b0, 15, 15);
        chk("t5_valid", op_valid, 1'b1);
        chk("t5_e", e_out, 8'hFF);
        chk("t5_f", f_out, 8'h00);
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        chk("t5_idle", dbg_state, S_IDLE);

        // 6: reset mid LOAD_E, then back-to-back frames on the LSB-first instance
        pulse_start();
        send_bits(8'hFF, 8'hFF, 1'b0, 1'b0, 0, 2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t6_rst_state", dbg_state, S_IDLE);
        chk("t6_rst_e", e_out, 8'h00);
        chk("t6_rst_f", f_out, 8'h00);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_valid", op_valid, 1'b0);
        chk("t6_rst_lsb_state", dbg_state_lsb, S_IDLE);
        pulse_start();
        send_bits(8'h01, 8'h01, 1'b0, 1'b1, 0, 15);
        chk("t6_lsb_valid", op_valid_lsb, 1'b1);
        chk("t6_lsb_e1", e_lsb, 8'h01);
        chk("t6_lsb_f1", f_lsb, 8'h01);
        chk("t6_msb_e1", e_out, 8'h80);
        op_ready = 1'b1;
        start = 1'b1;
        tick();
        op_ready = 1'b0;
        start = 1'b0;
        chk("t6_b2b_state", dbg_state_lsb, S_LOAD_E);
        chk("t6_b2b_valid", op_valid_lsb, 1'b0);
        chk("t6_b2b_err", frame_err_lsb, 1'b0);
        chk("t6_b2b_busy", busy_lsb, 1'b1);
        send_bits(8'h01, 8'h80, 1'b0, 1'b1, 0, 15);
        chk("t6_lsb_valid2", op_valid_lsb, 1'b1);
        chk("t6_lsb_e2", e_lsb, 8'h01);
        chk("t6_lsb_f2", f_lsb, 8'h80);
        chk("t6_msb_e2", e_out, 8'h80);
        chk("t6_msb_f2", f_out, 8'h01);

        // final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
